instr_fetch_queue: RTL and testbench

Decoupling buffer between the instruction fetch stage and the decode stage of the RV32 core. Captures each fetched instruction with its PC and PC+4 into a small FIFO, presents the oldest entry to decode with a valid/ready handshake, and back-pressures fetch when full. A redirect (taken branch/jump) flushes all queued entries so wrong-path instructions never reach decode.

---
 rtl/instr_fetch_queue.sv | 104 ++++++++++
 tb/tb_instr_fetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode decoupling FIFO: holds {pc, pc+4, instr, misalign} per entry,
// presents the oldest entry to decode, and discards everything on a redirect flush.
module instr_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_pc_pls4,
  input  logic [31:0]                  in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_pc_pls4,
  output logic [31:0]                  out_instr,
  output logic                         out_misalign,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never waits on ready, and ready depends only on registered count.

  logic [XLEN-1:0] pc_q      [DEPTH];
  logic [XLEN-1:0] pc_pls4_q [DEPTH];
  logic [31:0]     instr_q   [DEPTH];
  logic            mis_q     [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is never cleared; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]      <= in_pc;
      pc_pls4_q[wr_ptr_q] <= in_pc_pls4;
      instr_q[wr_ptr_q]   <= in_instr;
      mis_q[wr_ptr_q]     <= |in_pc[1:0];
    end
  end

  always_comb begin
    out_pc       = '0;
    out_pc_pls4  = '0;
    out_instr    = NOP;
    out_misalign = 1'b0;
    if (out_valid) begin
      out_pc       = pc_q[rd_ptr_q];
      out_pc_pls4  = pc_pls4_q[rd_ptr_q];
      out_instr    = instr_q[rd_ptr_q];
      out_misalign = mis_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: vector table, hand-written reset,
// streaming and random sequences, all checked against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = 97;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk, rstn, flush, in_valid, in_ready, out_valid, out_ready, out_misalign;
  logic [XLEN-1:0] in_pc, in_pc_pls4, out_pc, out_pc_pls4;
  logic [31:0]     in_instr, out_instr;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected queue: {misalign, instr, pc_pls4, pc}, oldest at index 0.
  logic [W-1:0] exp_q[$];

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_pls4(in_pc_pls4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_pls4(out_pc_pls4), .out_instr(out_instr),
    .out_misalign(out_misalign), .count(count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] head;
    int           sz;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : {1'b0, NOP, 32'h0, 32'h0};
    chk({tag, ".count"},        128'(count),        128'(sz));
    chk({tag, ".in_ready"},     128'(in_ready),     128'(sz != DEPTH));
    chk({tag, ".out_valid"},    128'(out_valid),    128'(sz != 0));
    chk({tag, ".out_pc"},       128'(out_pc),       128'(head[31:0]));
    chk({tag, ".out_pc_pls4"},  128'(out_pc_pls4),  128'(head[63:32]));
    chk({tag, ".out_instr"},    128'(out_instr),    128'(head[95:64]));
    chk({tag, ".out_misalign"}, 128'(out_misalign), 128'(head[96]));
  endtask

  // Driver: apply one cycle of inputs, check the pre-edge outputs, advance the model.
  task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ordy, input logic fl);
    logic m_push, m_pop;
    in_valid   = iv;
    in_pc      = pc;
    in_pc_pls4 = pc + 32'd4;
    in_instr   = instr;
    out_ready  = ordy;
    flush      = fl;
    #2;
    check_outputs(tag);
    m_push = iv && (exp_q.size() != DEPTH) && !fl;
    m_pop  = (exp_q.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({|pc[1:0], instr, pc + 32'd4, pc});
    end
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ordy;
    logic        fl;
    logic [1:0]  exp_count;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] instr, logic ordy,
                              logic fl, logic [1:0] ec, logic [31:0] epc, logic em);
    vec_t v;
    v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy; v.fl = fl;
    v.exp_count = ec; v.exp_pc = epc; v.exp_mis = em;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    logic [31:0] pc;
    vecs[0]  = mk(1, 32'h000, 32'h0000_0093, 0, 0, 2'd1, 32'h000, 0);
    vecs[1]  = mk(1, 32'h004, 32'h0010_0093, 0, 0, 2'd2, 32'h000, 0);
    vecs[2]  = mk(1, 32'h008, 32'h0020_0093, 0, 0, 2'd2, 32'h000, 0);
    vecs[3]  = mk(1, 32'h008, 32'h0020_0093, 1, 0, 2'd1, 32'h004, 0);
    vecs[4]  = mk(1, 32'h008, 32'h0020_0093, 1, 0, 2'd1, 32'h008, 0);
    vecs[5]  = mk(0, 32'h000, 32'h0000_0000, 1, 0, 2'd0, 32'h000, 0);
    vecs[6]  = mk(1, 32'h102, 32'h00A0_0093, 0, 0, 2'd1, 32'h102, 1);
    vecs[7]  = mk(1, 32'h104, 32'h0010_0113, 1, 0, 2'd1, 32'h104, 0);
    vecs[8]  = mk(0, 32'h000, 32'h0000_0000, 1, 0, 2'd0, 32'h000, 0);
    vecs[9]  = mk(1, 32'h010, 32'h0030_0093, 0, 0, 2'd1, 32'h010, 0);
    vecs[10] = mk(1, 32'h014, 32'h0040_0093, 0, 0, 2'd2, 32'h010, 0);
    vecs[11] = mk(1, 32'h200, 32'h0050_0093, 1, 1, 2'd0, 32'h000, 0);
    vecs[12] = mk(1, 32'h300, 32'h0060_0093, 0, 0, 2'd1, 32'h300, 0);
    vecs[13] = mk(0, 32'h000, 32'h0000_0000, 1, 0, 2'd0, 32'h000, 0);

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_pc_pls4 = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #2;
    check_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table: fill/drain, misalign, flush then re-push
    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d.count_after", i), 128'(count), 128'(vecs[i].exp_count));
      chk($sformatf("vec%0d.pc_after", i),    128'(out_pc), 128'(vecs[i].exp_pc));
      chk($sformatf("vec%0d.mis_after", i),   128'(out_misalign), 128'(vecs[i].exp_mis));
    end

    // Asynchronous reset mid-stream with two entries held
    step("rst_fill0", 1, 32'h040, 32'h0070_0093, 0, 0);
    step("rst_fill1", 1, 32'h044, 32'h0080_0093, 0, 0);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst.out_valid", 128'(out_valid), 128'(0));
    chk("async_rst.out_instr", 128'(out_instr), 128'(NOP));
    chk("async_rst.in_ready",  128'(in_ready),  128'(1));
    chk("async_rst.count",     128'(count),     128'(0));
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: one in, one out every cycle across pointer wrap
    for (int k = 0; k < 20; k++) begin
      step($sformatf("stream%0d", k), 1, 32'h100 + 32'(4 * k), 32'h0000_0093 | 32'(k << 20), 1, 0);
      chk($sformatf("stream%0d.count", k), 128'(count), 128'(1));
    end
    step("stream_drain", 0, 32'h0, 32'h0, 1, 0);
    chk("stream_drain.count", 128'(count), 128'(0));

    // Random traffic with occasional flush
    for (int n = 0; n < 400; n++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      step($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), pc, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 5));
      chk($sformatf("rand%0d.count_bound", n), 128'(count <= DEPTH), 128'(1));
    end
    for (int n = 0; n < DEPTH + 1; n++) step("final_drain", 0, 32'h0, 32'h0, 1, 0);
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
